inst_cache: RTL and testbench

- Direct-mapped instruction cache; responder side of the instruction-fetch interface.
- Fetch unit drives `fetch_addr`; cache answers in the same cycle with `inst_available` and `inst` on a hit.
- On a miss, a fill FSM reads the whole line word-by-word from the memory controller, then validates the line.
- Sits between the fetch unit and the memory controller.

---
 rtl/inst_cache.sv | 149 ++++++++++++++
 tb/tb_inst_cache.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache sitting between the fetch unit and the
// memory controller. Lookup is purely combinational from register arrays;
// a miss starts a line fill that reads every word of the line in order.
//
// Ports:
//   clk_in          clock
//   rst_in          synchronous active-high reset
//   rdy_in          global ready, low freezes all state
//   fetch_addr      PC from the fetch unit (bits [1:0] ignored)
//   inst_available  combinational hit for fetch_addr
//   inst            instruction word at fetch_addr (meaningful on a hit)
//   mem_req         word-read request, high for the whole fill
//   mem_addr        word-aligned read address
//   mem_data        returned word
//   mem_data_valid  one-cycle strobe, mem_data answers mem_addr
module inst_cache #(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] fetch_addr,
  output logic        inst_available,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned IDX_LSB  = OFFSET_BITS + 2;
  localparam int unsigned TAG_LSB  = OFFSET_BITS + INDEX_BITS + 2;
  localparam int unsigned TAG_BITS = 32 - TAG_LSB;

  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  // Storage arrays; data and tag are never reset, only valid bits are.
  logic [31:0]         data_q [LINES][WORDS];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  logic [0:0]             state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]  fill_index_q, fill_index_d;
  logic [TAG_BITS-1:0]    fill_tag_q, fill_tag_d;
  logic                   mem_req_d;
  logic [31:0]            mem_addr_d;

  logic                   start_fill_c;
  logic                   word_we_c;
  logic                   line_done_c;

  // Address split of the fetch PC.
  logic [OFFSET_BITS-1:0] f_offset;
  logic [INDEX_BITS-1:0]  f_index;
  logic [TAG_BITS-1:0]    f_tag;
  logic                   hit_c;
  logic                   unused_addr_bits;

  assign f_offset         = fetch_addr[IDX_LSB-1:2];
  assign f_index          = fetch_addr[TAG_LSB-1:IDX_LSB];
  assign f_tag            = fetch_addr[31:TAG_LSB];
  assign unused_addr_bits = ^fetch_addr[1:0];

  // Combinational lookup, served in every FSM state.
  assign hit_c          = valid_q[f_index] && (tag_q[f_index] == f_tag);
  assign inst_available = hit_c;
  assign inst           = data_q[f_index][f_offset];

  // Next-state logic; nothing advances while rdy_in is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_index_d = fill_index_q;
    fill_tag_d   = fill_tag_q;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    start_fill_c = 1'b0;
    word_we_c    = 1'b0;
    line_done_c  = 1'b0;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (!hit_c) begin
            start_fill_c = 1'b1;
            state_d      = FILL;
            cnt_d        = '0;
            fill_index_d = f_index;
            fill_tag_d   = f_tag;
            mem_req_d    = 1'b1;
            mem_addr_d   = {f_tag, f_index, {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (mem_data_valid) begin
            word_we_c = 1'b1;
            if (cnt_q == LAST_WORD) begin
              line_done_c = 1'b1;
              state_d     = IDLE;
              cnt_d       = '0;
              mem_req_d   = 1'b0;
            end else begin
              cnt_d      = cnt_q + OFFSET_BITS'(1);
              mem_addr_d = mem_addr + 32'd4;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and valid bits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_index_q <= fill_index_d;
      fill_tag_q   <= fill_tag_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      // Invalidate the victim as soon as the fill is committed so a partial
      // line can never hit.
      if (start_fill_c) valid_q[f_index] <= 1'b0;
      if (line_done_c)  valid_q[fill_index_q] <= 1'b1;
    end
  end

  // Data and tag arrays, written only by the fill.
  always_ff @(posedge clk_in) begin
    if (!rst_in && word_we_c)   data_q[fill_index_q][cnt_q] <= mem_data;
    if (!rst_in && line_done_c) tag_q[fill_index_q] <= fill_tag_q;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus a randomized
// phase, all compared against a line-level model backed by a memory image.
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        inst_available;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  inst_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .fetch_addr     (fetch_addr),
    .inst_available (inst_available),
    .inst           (inst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid)
  );

  always #5 clk_in = ~clk_in;

  // Backing memory: explicit words override a fixed address hash.
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_img.exists(w)) return mem_img[w];
    return (w * 32'h9E3779B1) ^ 32'h5EED1234;
  endfunction

  // Model: which line address each set currently holds, plus the fill
  // in flight expressed as a line base and a word number.
  bit          m_init = 1'b0;
  bit          m_res [16];
  logic [31:0] m_line [16];
  bit          m_busy = 1'b0;
  logic [31:0] m_base = '0;
  int          m_word = 0;
  logic [31:0] m_addr = '0;
  bit          m_addr_known = 1'b0;
  int          wait_cnt = 0;
  int          lat_q[$];

  function automatic int next_lat();
    if (lat_q.size() > 0) return lat_q.pop_front();
    return int'($urandom_range(0, 3));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'(a[7:4]);
    return m_res[s] && (m_line[s] == {a[31:4], 4'h0});
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input logic [31:0] fa, input logic rdy = 1'b1, input logic rst = 1'b0);
    bit strobe;
    bit hit_e;
    @(negedge clk_in);
    fetch_addr = fa;
    rdy_in     = rdy;
    rst_in     = rst;
    strobe     = m_busy && rdy && !rst && (wait_cnt == 0);
    // While frozen, occasionally emit a bogus strobe that must be ignored.
    mem_data_valid = strobe || (m_busy && !rdy && ($urandom_range(0, 1) == 1));
    mem_data       = strobe ? mem_rd(m_addr) : $urandom();
    #1;
    hit_e = model_hit(fa);
    if (m_init) begin
      check("avail", 32'(inst_available), 32'(hit_e));
      if (hit_e) check("inst", inst, mem_rd(fa));
      check("mem_req", 32'(mem_req), 32'(m_busy));
      if (m_addr_known) check("mem_addr", mem_addr, m_addr);
    end
    if (rst) begin
      m_init = 1'b1;
      for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
      m_busy = 1'b0;
      m_word = 0;
      m_addr = '0;
      m_addr_known = 1'b1;
    end else if (rdy && m_init) begin
      if (!m_busy) begin
        if (!hit_e) begin
          m_res[int'(fa[7:4])] = 1'b0;
          m_busy = 1'b1;
          m_base = {fa[31:4], 4'h0};
          m_word = 0;
          m_addr = m_base;
          m_addr_known = 1'b1;
          wait_cnt = next_lat();
        end
      end else if (strobe) begin
        if (m_word == 3) begin
          m_res[int'(m_base[7:4])]  = 1'b1;
          m_line[int'(m_base[7:4])] = m_base;
          m_busy = 1'b0;
          m_addr_known = 1'b0;
        end else begin
          m_word++;
          m_addr = m_addr + 32'd4;
          wait_cnt = next_lat();
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
  endtask

  // Hold fa until a fill starts and completes.
  task automatic run_fill(input logic [31:0] fa);
    bit started;
    bit done;
    started = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(fa);
      if (started && !m_busy) done = 1'b1;
      if (m_busy) started = 1'b1;
    end
    if (!done) check("fill_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_to_word(input logic [31:0] fa, input int w);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      step(fa);
      if (m_busy && m_word == w) reached = 1'b1;
    end
    if (!reached) check("word_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] fa;
  logic [31:0] base;
  int          hold;

  initial begin
    mem_img[32'h0] = 32'h11111111;
    mem_img[32'h4] = 32'h22222222;
    mem_img[32'h8] = 32'h33333333;
    mem_img[32'hC] = 32'h44444444;

    step(32'h0, 1'b1, 1'b1);
    step(32'h0, 1'b1, 1'b1);

    // Cold miss with two-cycle responses.
    lat_q = '{1, 1, 1, 1};
    step(32'h0);
    check("t1_cold_miss", 32'(inst_available), 32'd0);
    step(32'h0);
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr0", mem_addr, 32'h0);
    run_fill(32'h0);
    step(32'h0);
    check("t1_req_drop", 32'(mem_req), 32'd0);
    check("t1_word0", inst, 32'h11111111);
    step(32'hA);
    check("t1_word2", inst, 32'h33333333);

    // Conflict eviction on set 0.
    run_fill(32'h100);
    step(32'h100);
    check("t2_hit", 32'(inst_available), 32'd1);
    step(32'h0);
    check("t2_evicted", 32'(inst_available), 32'd0);
    step(32'h0);
    check("t2_refill_addr", mem_addr, 32'h0);
    run_fill(32'h0);

    // Hit under fill.
    run_fill(32'h10);
    lat_q = '{2, 2, 2, 2};
    step(32'h20);
    step(32'h14);
    check("t3_hit_under_fill", 32'(inst_available), 32'd1);
    check("t3_req_high", 32'(mem_req), 32'd1);
    check("t3_word1", inst, mem_rd(32'h14));
    step(32'h24);
    check("t3_fill_line_miss", 32'(inst_available), 32'd0);
    run_fill(32'h24);
    step(32'h24);
    check("t3_filled", 32'(inst_available), 32'd1);

    // Freeze after the second strobe.
    base = 32'h230;
    run_to_word(base, 2);
    for (int i = 0; i < 5; i++) begin
      step(base, 1'b0);
      check("t4_req_hold", 32'(mem_req), 32'd1);
      check("t4_addr_hold", mem_addr, base + 32'd8);
    end
    run_fill(base);
    for (int w = 0; w < 4; w++) step(base + 32'(w * 4));

    // Reset mid-fill, then refetch from word 0.
    base = 32'h350;
    run_to_word(base, 2);
    step(base, 1'b1, 1'b1);
    step(base);
    check("t5_req_low", 32'(mem_req), 32'd0);
    check("t5_miss", 32'(inst_available), 32'd0);
    step(base);
    check("t5_restart", mem_addr, base);
    run_fill(base);

    // Variable latency with fetch address wandering mid-fill.
    base = 32'h1460;
    lat_q = '{0, 7, 1, 3};
    step(base);
    for (int i = 0; i < 200 && m_busy; i++) begin
      fa = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
           | 32'($urandom_range(0, 15));
      step(fa);
    end
    if (m_busy) check("t6_timeout", 32'd0, 32'd1);
    for (int w = 0; w < 4; w++) begin
      step(base + 32'(w * 4));
      check("t6_data", inst, mem_rd(base + 32'(w * 4)));
    end

    // Randomized traffic over a small working set.
    for (int i = 0; i < 150; i++) begin
      fa = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
           | 32'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 8));
      for (int j = 0; j < hold; j++)
        step(fa, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
